sdio_cmdframe: RTL and testbench

Host-side SDIO command-line engine. Serializes a 48-bit command frame with CRC7 onto the CMD wire, then waits for and deserializes the card's reply (48-bit R1/R3/R6/R7 or 136-bit R2), checking start, direction, end bits and CRC. It sits directly upstream of the card's command wire handler: it drives what the card decodes and consumes what the card replies. Bit timing comes from an external clock-enable strobe, so one fabric clock serves every SD clock rate.

---
 rtl/sdio_cmdframe.sv | 213 +++++++++++++++++++++
 tb/tb_sdio_cmdframe.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdio_cmdframe.sv
// Host-side SDIO CMD-line engine: sends a CRC7-protected 48-bit command, then collects and
// validates the card's 48- or 136-bit reply. Bit timing comes from the i_ckstb strobe.
module sdio_cmdframe #(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned NCC     = 8
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_ckstb,
    input  logic         i_request,
    input  logic [1:0]   i_type,
    input  logic [5:0]   i_cmd,
    input  logic [31:0]  i_arg,
    output logic         o_busy,
    output logic         o_done,
    output logic [1:0]   o_err,
    output logic [5:0]   o_resp,
    output logic [119:0] o_arg,
    input  logic         i_cmd_in,
    output logic         o_cmd,
    output logic         o_cmd_en
);
    localparam int unsigned MaxTN  = (TIMEOUT > NCC) ? TIMEOUT : NCC;
    localparam int unsigned CntMax = (MaxTN > 136) ? MaxTN : 136;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    localparam logic [1:0] TypeNone   = 2'd0;
    localparam logic [1:0] TypeR2     = 2'd2;
    localparam logic [1:0] TypeR3     = 2'd3;
    localparam logic [1:0] ErrOk      = 2'd0;
    localparam logic [1:0] ErrTimeout = 2'd1;
    localparam logic [1:0] ErrCrc     = 2'd2;
    localparam logic [1:0] ErrFrame   = 2'd3;

    typedef enum logic [2:0] {StIdle, StTx, StWait, StRx, StNcc} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [47:0]     frame_q, frame_d;
    logic [1:0]      type_q, type_d;
    logic [134:0]    shift_q, shift_d;
    logic [6:0]      crc_q, crc_d;
    logic            cmd_q, cmd_d;
    logic            cmd_en_q, cmd_en_d;
    logic            done_q, done_d;
    logic [1:0]      err_q, err_d;
    logic [5:0]      resp_q, resp_d;
    logic [119:0]    arg_q, arg_d;

    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic bit_in);
        logic fb;
        fb = crc[6] ^ bit_in;
        return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    function automatic logic [6:0] crc7_40(input logic [39:0] d);
        logic [6:0] c;
        c = '0;
        for (int i = 39; i >= 0; i--) begin
            c = crc7_step(c, d[i]);
        end
        return c;
    endfunction

    // Full received word including the bit sampled on this strobe.
    logic [135:0] shift_in;
    logic         rx_long, rx_last, rx_crc_bit, frame_bad;

    assign shift_in   = {shift_q, i_cmd_in};
    assign rx_long    = (type_q == TypeR2);
    assign rx_last    = rx_long ? (cnt_q == CntW'(135)) : (cnt_q == CntW'(47));
    assign rx_crc_bit = rx_long ? (cnt_q >= CntW'(8) && cnt_q < CntW'(128))
                                : (cnt_q < CntW'(40));
    assign frame_bad  = rx_long ? (shift_in[135] || shift_in[134] || !shift_in[0])
                                : (shift_in[47] || shift_in[46] || !shift_in[0]);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        frame_d  = frame_q;
        type_d   = type_q;
        shift_d  = shift_q;
        crc_d    = crc_q;
        cmd_d    = cmd_q;
        cmd_en_d = cmd_en_q;
        done_d   = 1'b0;
        err_d    = err_q;
        resp_d   = resp_q;
        arg_d    = arg_q;

        unique case (state_q)
            StIdle: begin
                // The clock carrying o_done still counts as busy for acceptance.
                if (i_request && !done_q) begin
                    state_d = StTx;
                    cnt_d   = '0;
                    type_d  = i_type;
                    frame_d = {2'b01, i_cmd, i_arg, crc7_40({2'b01, i_cmd, i_arg}), 1'b1};
                end
            end
            StTx: begin
                if (i_ckstb) begin
                    cmd_d    = frame_q[47];
                    cmd_en_d = 1'b1;
                    frame_d  = {frame_q[46:0], 1'b1};
                    if (cnt_q == CntW'(47)) begin
                        cnt_d   = '0;
                        state_d = (type_q == TypeNone) ? StNcc : StWait;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StWait: begin
                if (i_ckstb) begin
                    cmd_d    = 1'b1;
                    cmd_en_d = 1'b0;
                    if (!i_cmd_in) begin
                        state_d = StRx;
                        shift_d = '0;
                        crc_d   = '0;
                        cnt_d   = CntW'(1);
                    end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                        err_d   = ErrTimeout;
                        resp_d  = '0;
                        arg_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StRx: begin
                if (i_ckstb) begin
                    shift_d = shift_in[134:0];
                    cnt_d   = cnt_q + 1'b1;
                    if (rx_crc_bit) begin
                        crc_d = crc7_step(crc_q, i_cmd_in);
                    end
                    if (rx_last) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                        if (frame_bad) begin
                            err_d = ErrFrame;
                        end else if (type_q != TypeR3 && crc_q != shift_in[7:1]) begin
                            err_d = ErrCrc;
                        end else begin
                            err_d = ErrOk;
                        end
                        resp_d = rx_long ? shift_in[133:128] : shift_in[45:40];
                        arg_d  = rx_long ? shift_in[127:8] : {88'd0, shift_in[39:8]};
                    end
                end
            end
            StNcc: begin
                if (i_ckstb) begin
                    cmd_d    = 1'b1;
                    cmd_en_d = 1'b0;
                    if (cnt_q == CntW'(NCC - 1)) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                        err_d   = ErrOk;
                        resp_d  = '0;
                        arg_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            frame_q  <= '0;
            type_q   <= '0;
            shift_q  <= '0;
            crc_q    <= '0;
            cmd_q    <= 1'b1;
            cmd_en_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= '0;
            resp_q   <= '0;
            arg_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            frame_q  <= frame_d;
            type_q   <= type_d;
            shift_q  <= shift_d;
            crc_q    <= crc_d;
            cmd_q    <= cmd_d;
            cmd_en_q <= cmd_en_d;
            done_q   <= done_d;
            err_q    <= err_d;
            resp_q   <= resp_d;
            arg_q    <= arg_d;
        end
    end

    assign o_busy   = (state_q != StIdle);
    assign o_done   = done_q;
    assign o_err    = err_q;
    assign o_resp   = resp_q;
    assign o_arg    = arg_q;
    assign o_cmd    = cmd_q;
    assign o_cmd_en = cmd_en_q;

endmodule

// File: tb/tb_sdio_cmdframe.sv
// Bench for sdio_cmdframe: fixed vectors, reset/busy corner sequences and random commands
// with a card model driving replies and a CRC-by-long-division reference.
module tb_sdio_cmdframe;
    localparam int unsigned TIMEOUT = 64;
    localparam int unsigned NCC     = 8;

    logic         clk = 1'b0;
    logic         i_reset, i_ckstb, i_request, i_cmd_in;
    logic [1:0]   i_type;
    logic [5:0]   i_cmd;
    logic [31:0]  i_arg;
    logic         o_busy, o_done, o_cmd, o_cmd_en;
    logic [1:0]   o_err;
    logic [5:0]   o_resp;
    logic [119:0] o_arg;

    always #5 clk = ~clk;

    sdio_cmdframe #(.TIMEOUT(TIMEOUT), .NCC(NCC)) dut (
        .i_clk    (clk),
        .i_reset  (i_reset),
        .i_ckstb  (i_ckstb),
        .i_request(i_request),
        .i_type   (i_type),
        .i_cmd    (i_cmd),
        .i_arg    (i_arg),
        .o_busy   (o_busy),
        .o_done   (o_done),
        .o_err    (o_err),
        .o_resp   (o_resp),
        .o_arg    (o_arg),
        .i_cmd_in (i_cmd_in),
        .o_cmd    (o_cmd),
        .o_cmd_en (o_cmd_en)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [135:0] act, input logic [135:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // CRC7 as the remainder of msg * x^7 divided by x^7+x^3+1.
    function automatic logic [6:0] crc_div(input logic [119:0] msg, input int nbits);
        logic [126:0] r;
        r = {7'd0, msg} << 7;
        for (int i = nbits + 6; i >= 7; i--) begin
            if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
        end
        return r[6:0];
    endfunction

    function automatic logic [47:0] mk_frame(input logic [5:0] cmd, input logic [31:0] arg);
        logic [39:0] m;
        m = {2'b01, cmd, arg};
        return {m, crc_div({80'd0, m}, 40), 1'b1};
    endfunction

    function automatic void model_reply(input logic [135:0] rep, input int rlen,
                                        input logic [1:0] typ, output logic [1:0] err,
                                        output logic [5:0] resp, output logic [119:0] arg);
        logic crc_ok;
        err = 2'd0; resp = '0; arg = '0;
        if (typ == 2'd0) return;
        if (rlen == 0) begin
            err = 2'd1;
            return;
        end
        if (typ == 2'd2) begin
            crc_ok = (crc_div(rep[127:8], 120) == rep[7:1]);
            resp   = 6'h3F;
            arg    = rep[127:8];
        end else begin
            crc_ok = (crc_div({80'd0, rep[47:8]}, 40) == rep[7:1]);
            resp   = rep[45:40];
            arg    = {88'd0, rep[39:8]};
        end
        if (rep[rlen-2] || !rep[0]) err = 2'd3;
        else if (typ != 2'd3 && !crc_ok) err = 2'd2;
    endfunction

    // Card model and strobe pattern state.
    logic [135:0] cur_rep;
    int           cur_len, cur_delay, cur_div;
    int           ridx, wstb, tx_bits, phase;
    logic [47:0]  tx_frame;

    task automatic card_setup(input logic [135:0] rep, input int rlen, input int delay,
                              input int div);
        cur_rep = rep; cur_len = rlen; cur_delay = delay; cur_div = div;
        ridx = 0; wstb = 0; tx_bits = 0; phase = 0; tx_frame = '0;
    endtask

    task automatic cycle(input logic req);
        logic stb;
        @(negedge clk);
        if (cur_div == 0) stb = 1'($urandom_range(0, 1));
        else stb = ((phase % cur_div) == 0);
        phase++;
        i_ckstb   = stb;
        i_request = req;
        if (stb && tx_bits == 48) begin
            if (wstb + 1 >= cur_delay && ridx < cur_len) begin
                i_cmd_in = cur_rep[cur_len-1-ridx];
                ridx++;
            end else begin
                i_cmd_in = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        if (stb) begin
            if (tx_bits < 48) begin
                if (o_cmd_en) begin
                    tx_frame = {tx_frame[46:0], o_cmd};
                    tx_bits++;
                end
            end else begin
                wstb++;
            end
        end
    endtask

    task automatic run_cmd(input string tag, input logic [5:0] cmd, input logic [31:0] arg,
                           input logic [1:0] typ, input logic [135:0] rep, input int rlen,
                           input int delay, input int div, input logic [47:0] exp_frame,
                           input logic [1:0] exp_err, input logic [5:0] exp_resp,
                           input logic [119:0] exp_arg, input logic poke);
        int   lat_exp;
        logic seen, poked, req_now;
        card_setup(rep, rlen, delay, div);
        seen = 1'b0; poked = 1'b0;
        i_cmd = cmd; i_arg = arg; i_type = typ; i_cmd_in = 1'b1;
        cycle(1'b1);
        check($sformatf("%s_busy", tag), o_busy, 1'b1);
        // Scramble inputs: the engine must work from its latched copy.
        i_cmd = ~cmd; i_arg = ~arg; i_type = ~typ;
        for (int cyc = 0; cyc < 5000 && !seen; cyc++) begin
            req_now = poke && !poked && tx_bits == 48 && wstb == 3;
            if (req_now) poked = 1'b1;
            cycle(req_now);
            if (o_done) seen = 1'b1;
        end
        lat_exp = (typ == 2'd0) ? NCC : (rlen == 0) ? TIMEOUT : delay + rlen - 1;
        check($sformatf("%s_done", tag), seen, 1'b1);
        check($sformatf("%s_txbits", tag), 136'(tx_bits), 136'(48));
        check($sformatf("%s_frame", tag), tx_frame, exp_frame);
        check($sformatf("%s_latency", tag), 136'(wstb), 136'(lat_exp));
        check($sformatf("%s_busy_at_done", tag), o_busy, 1'b0);
        check($sformatf("%s_err", tag), o_err, exp_err);
        if (typ == 2'd0 || rlen != 0) begin
            check($sformatf("%s_resp", tag), o_resp, exp_resp);
            check($sformatf("%s_arg", tag), o_arg, exp_arg);
        end
        cycle(poke);
        check($sformatf("%s_done_pulse", tag), o_done, 1'b0);
        check($sformatf("%s_req_on_done", tag), o_busy, 1'b0);
        cycle(1'b0);
        check($sformatf("%s_no_queue", tag), o_busy, 1'b0);
    endtask

    typedef struct {
        logic [5:0]   cmd;
        logic [31:0]  arg;
        logic [1:0]   typ;
        logic [135:0] rep;
        int           rlen;
        int           delay;
        int           div;
        logic [47:0]  frame;
        logic [1:0]   err;
        logic [5:0]   resp;
        logic [119:0] oarg;
    } vec_t;

    function automatic vec_t mk(input logic [5:0] cmd, input logic [31:0] arg,
                                input logic [1:0] typ, input logic [135:0] rep, input int rlen,
                                input int delay, input int div, input logic [1:0] err,
                                input logic [5:0] resp, input logic [119:0] oarg);
        vec_t v;
        v.cmd = cmd; v.arg = arg; v.typ = typ; v.rep = rep; v.rlen = rlen;
        v.delay = delay; v.div = div; v.frame = mk_frame(cmd, arg);
        v.err = err; v.resp = resp; v.oarg = oarg;
        return v;
    endfunction

    vec_t         vecs[8];
    logic [1:0]   r_typ, m_err;
    logic [5:0]   r_cmd, r_idx, m_resp;
    logic [31:0]  r_arg, r_ra;
    logic [119:0] r_data, m_arg;
    logic [135:0] r_rep;
    int           r_len, r_mode, r_div, r_delay, r_bit, n_done;

    initial begin
        i_reset = 1'b1; i_ckstb = 1'b0; i_request = 1'b0; i_cmd_in = 1'b1;
        i_type = '0; i_cmd = '0; i_arg = '0;
        card_setup('0, 0, 1, 1);
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", o_busy, 1'b0);
        check("rst_done", o_done, 1'b0);
        check("rst_err", o_err, 2'd0);
        check("rst_resp", o_resp, 6'd0);
        check("rst_arg", o_arg, 120'd0);
        check("rst_cmd", o_cmd, 1'b1);
        check("rst_cmd_en", o_cmd_en, 1'b0);
        @(negedge clk);
        i_reset = 1'b0;

        vecs[0] = mk(6'd8, 32'h1AA, 2'd1, 136'h08000001AA13, 48, 2, 1, 2'd0, 6'd8, 120'h1AA);
        vecs[0].frame = 48'h48000001AA87;
        vecs[1] = mk(6'd0, 32'h0, 2'd0, '0, 0, 1, 1, 2'd0, 6'd0, 120'd0);
        vecs[1].frame = 48'h400000000095;
        vecs[2] = mk(6'd41, 32'h40FF8000, 2'd3, 136'h3F80FF8000FF, 48, 3, 2, 2'd0, 6'h3F,
                     120'h80FF8000);
        vecs[3] = mk(6'd8, 32'h1AA, 2'd1, '0, 0, 1, 1, 2'd1, 6'd0, 120'd0);
        vecs[4] = mk(6'd55, 32'h0, 2'd1, '0, 0, 1, 4, 2'd1, 6'd0, 120'd0);
        vecs[5] = mk(6'd8, 32'h1AA, 2'd1, 136'h08000001AB13, 48, 2, 1, 2'd2, 6'd8, 120'h1AB);
        vecs[6] = mk(6'd8, 32'h1AA, 2'd1, 136'h08000001AA12, 48, 5, 3, 2'd3, 6'd8, 120'h1AA);
        vecs[7] = mk(6'd8, 32'h1AA, 2'd1, 136'h48000001AA13, 48, 2, 0, 2'd3, 6'd8, 120'h1AA);
        for (int i = 0; i < 8; i++) begin
            run_cmd($sformatf("v%0d", i), vecs[i].cmd, vecs[i].arg, vecs[i].typ, vecs[i].rep,
                    vecs[i].rlen, vecs[i].delay, vecs[i].div, vecs[i].frame, vecs[i].err,
                    vecs[i].resp, vecs[i].oarg, 1'b0);
        end

        // Reset in the middle of the command frame.
        card_setup('0, 0, 1, 1);
        i_cmd = 6'd8; i_arg = 32'h1AA; i_type = 2'd1;
        cycle(1'b1);
        for (int g = 0; g < 200 && tx_bits < 20; g++) cycle(1'b0);
        check("midtx_bit20", 136'(tx_bits), 136'(20));
        @(negedge clk);
        i_reset = 1'b1;
        @(posedge clk);
        #1;
        check("midtx_cmd_en", o_cmd_en, 1'b0);
        check("midtx_cmd", o_cmd, 1'b1);
        check("midtx_busy", o_busy, 1'b0);
        @(negedge clk);
        i_reset = 1'b0;
        n_done = 0;
        for (int g = 0; g < 150; g++) begin
            cycle(1'b0);
            if (o_done) n_done++;
        end
        check("midtx_no_done", 136'(n_done), 136'(0));

        // Reset and request on the same clock.
        @(negedge clk);
        i_reset = 1'b1; i_request = 1'b1;
        @(posedge clk);
        #1;
        check("rst_req_busy", o_busy, 1'b0);
        @(negedge clk);
        i_reset = 1'b0; i_request = 1'b0;
        @(posedge clk);
        #1;
        check("rst_req_after", o_busy, 1'b0);

        // Full frame after the abort, with requests poked during WAIT and on the done clock.
        run_cmd("after_rst", 6'd8, 32'h1AA, 2'd1, 136'h08000001AA13, 48, 4, 1, 48'h48000001AA87,
                2'd0, 6'd8, 120'h1AA, 1'b1);

        for (int it = 0; it < 40; it++) begin
            r_typ   = (it < 2) ? 2'd2 : 2'($urandom_range(0, 3));
            r_mode  = (it < 2) ? 0 : $urandom_range(0, 5);
            r_div   = $urandom_range(0, 3);
            r_delay = $urandom_range(2, 10);
            r_cmd   = 6'($urandom);
            r_arg   = $urandom;
            r_idx   = 6'($urandom);
            r_ra    = $urandom;
            r_data  = {$urandom, $urandom, $urandom, $urandom};
            if (r_typ == 2'd0) begin
                r_rep = '0;
                r_len = 0;
            end else if (r_typ == 2'd2) begin
                r_rep = {8'h3F, r_data, crc_div(r_data, 120), 1'b1};
                r_len = 136;
            end else begin
                r_rep = {88'd0, 2'b00, r_idx, r_ra,
                         (r_typ == 2'd3) ? 7'($urandom)
                                         : crc_div({80'd0, 2'b00, r_idx, r_ra}, 40), 1'b1};
                r_len = 48;
            end
            if (r_typ != 2'd0 && r_mode == 4) begin
                r_len = 0;
            end else if (r_typ != 2'd0 && (r_mode == 3 || r_mode == 5)) begin
                r_bit = $urandom_range(0, r_len - 2);
                if (r_typ == 2'd2 && r_bit >= 128 && r_bit <= 133) r_bit = 134;
                r_rep[r_bit] = ~r_rep[r_bit];
            end
            model_reply(r_rep, r_len, r_typ, m_err, m_resp, m_arg);
            run_cmd($sformatf("rnd%0d", it), r_cmd, r_arg, r_typ, r_rep, r_len, r_delay, r_div,
                    mk_frame(r_cmd, r_arg), m_err, m_resp, m_arg, 1'(r_mode & 1));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
